instruction_fetch: RTL and testbench

Upstream sequencing stage for the ALU datapath. Holds a small writable program store, steps a program counter through it, and presents each instruction as operand A, operand B and a 3-bit opcode to the datapath stage over a valid/ready handshake. Execution stops on an instruction word with the halt bit set. The program store is loaded through a dedicated write port while the block is idle or halted.

---
 rtl/instruction_fetch.sv | 55 +++++
 tb/tb_instruction_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: program store and PC sequencer issuing a/b/opcode to the datapath over valid/ready
module instruction_fetch #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [19:0]           prog_data,
    input  logic                  ready,
    output logic [7:0]            a,
    output logic [7:0]            b,
    output logic [2:0]            opcode,
    output logic                  valid,
    output logic [DEPTH_LOG2-1:0] pc,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
    state_t state, state_nx;
    logic [19:0] mem [2**DEPTH_LOG2];
    logic [19:0] word;
    logic [18:0] ir;
    logic        idle;
    assign word = mem[pc];
    assign idle = state == IDLE || state == HALTED;
    always_comb begin
        state_nx = state;
        if (idle && start) state_nx = FETCH;
        else if (state == FETCH) state_nx = word[19] ? HALTED : ISSUE;
        else if (state == ISSUE && ready) state_nx = FETCH;
    end
    always_ff @(posedge clk)
        if (prog_we && idle) mem[prog_addr] <= prog_data;
    // halt words never reach ir, so they can never appear on a/b/opcode
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == FETCH && word[19];
            if (idle && start) pc <= '0;
            else if (state == ISSUE && ready) pc <= pc + 1'b1;
            if (state == FETCH && !word[19]) ir <= word[18:0];
        end
    assign valid  = state == ISSUE;
    assign busy   = state == FETCH || state == ISSUE;
    assign opcode = ir[18:16];
    assign a      = ir[15:8];
    assign b      = ir[7:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch with DEPTH_LOG2=2
module tb_instruction_fetch;
    logic        clk = 0, rst = 0, start = 0, prog_we = 0, ready = 0;
    logic [1:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [7:0]  a, b;
    logic [2:0]  opcode;
    logic        valid, busy, done;
    logic [1:0]  pc;
    int passed = 0, total = 0;

    instruction_fetch #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .ready(ready),
        .a(a), .b(b), .opcode(opcode), .valid(valid), .pc(pc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [19:0] d);
        prog_we = 1; prog_addr = addr; prog_data = d;
        step();
        prog_we = 0;
    endtask

    task automatic chk_issue(input string tag, input int ea, input int eb, input int eop);
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_a"}, 32'(a), ea);
        chk({tag, "_b"}, 32'(b), eb);
        chk({tag, "_op"}, 32'(opcode), eop);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_abop", {13'd0, a, b, opcode}, 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1;
        ready = 1;
        repeat (3) step();
        chk("idle_valid", 32'(valid), 0);
        chk("idle_busy", 32'(busy), 0);
        ready = 0;

        wr(0, 20'h1_05_03);
        wr(1, 20'h2_0A_0F);
        wr(2, 20'h8_00_00);
        ready = 1; start = 1;
        step(); start = 0;
        chk("run_fetch_busy", 32'(busy), 1);
        chk("run_fetch_valid", 32'(valid), 0);
        step();
        chk_issue("run_i0", 'h05, 'h03, 1);
        chk("run_i0_pc", 32'(pc), 0);
        step();
        chk("run_hs0_valid", 32'(valid), 0);
        chk("run_hs0_pc", 32'(pc), 1);
        step();
        chk_issue("run_i1", 'h0A, 'h0F, 2);
        step();
        chk("run_hs1_valid", 32'(valid), 0);
        chk("run_hs1_pc", 32'(pc), 2);
        step();
        chk("run_halt_done", 32'(done), 1);
        chk("run_halt_busy", 32'(busy), 0);
        chk("run_halt_valid", 32'(valid), 0);
        chk("run_halt_pc", 32'(pc), 2);
        step();
        chk("run_done_clear", 32'(done), 0);
        chk("run_halt_pc_hold", 32'(pc), 2);

        ready = 0; start = 1;
        step(); start = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk_issue("bp_hold", 'h05, 'h03, 1);
            chk("bp_pc", 32'(pc), 0);
            step();
        end
        ready = 1;
        step();
        chk("bp_adv_valid", 32'(valid), 0);
        chk("bp_adv_pc", 32'(pc), 1);
        repeat (3) step();
        chk("bp_done", 32'(done), 1);

        ready = 0; start = 1;
        step(); start = 0;
        step();
        wr(1, 20'h7_FF_FF);
        chk_issue("wp_still_i0", 'h05, 'h03, 1);
        ready = 1;
        step();
        step();
        chk_issue("wp_old_i1", 'h0A, 'h0F, 2);
        repeat (2) step();
        chk("wp_done1", 32'(done), 1);
        wr(1, 20'h7_FF_FF);
        start = 1;
        step(); start = 0;
        repeat (3) step();
        chk_issue("wp_new_i1", 'hFF, 'hFF, 7);
        repeat (2) step();
        chk("wp_done2", 32'(done), 1);

        wr(0, 20'h1_11_01);
        wr(1, 20'h2_22_02);
        wr(2, 20'h3_33_03);
        wr(3, 20'h4_44_04);
        start = 1;
        step(); start = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("wrap_valid", 32'(valid), 1);
            chk("wrap_pc", 32'(pc), 32'(i % 4));
            chk("wrap_b", 32'(b), 32'(i % 4 + 1));
            chk("wrap_done_i", 32'(done), 0);
            step();
            chk("wrap_done_f", 32'(done), 0);
        end

        ready = 0;
        step();
        chk("ar_pre_valid", 32'(valid), 1);
        chk("ar_pre_pc", 32'(pc), 2);
        #2 rst = 0;
        #1;
        chk("ar_valid", 32'(valid), 0);
        chk("ar_abop", {13'd0, a, b, opcode}, 0);
        chk("ar_pc", 32'(pc), 0);
        chk("ar_busy", 32'(busy), 0);
        #2 rst = 1;
        start = 1;
        step(); start = 0;
        step();
        chk_issue("ar_rerun_i0", 'h11, 'h01, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
